// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Sequencing controller for the multi-cycle MIPS-subset CPU. Each instruction
// is stepped through fetch, decode, execute, memory and writeback states. The
// controller stalls on the memory-ready handshake and raises three exceptions:
// illegal opcode, ALU overflow and memory timeout. It also counts retired
// instructions.
//
// Parameters
//   MEM_TIMEOUT  wait cycles with mem_ready=0 before a bus-error exception (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   SYS_clk      system clock, rising edge
//   SYS_reset    synchronous active-high reset; forces every output to 0
//   opcode       instruction[31:26] from the instruction register
//   alu_zero     ALU zero flag
//   alu_ovf      ALU signed overflow flag
//   mem_ready    memory completes the current read/write this cycle
//   pc_write     load PC
//   iord         memory address select (0=PC, 1=ALU out)
//   mem_read     memory read request
//   mem_write    memory write request
//   ir_write     load instruction register
//   mem2reg      writeback select (1=memory data)
//   reg_write    register file write enable
//   reg_dst      destination select (1=rd, 0=rt)
//   alu_src_a    ALU A select (0=PC, 1=rs)
//   alu_src_b    ALU B select (00=rt, 01=4, 10=imm, 11=imm<<2)
//   alu_op       ALU op (00=add, 01=sub, 10=funct)
//   pc_source    PC source (00=ALU, 01=ALU out reg, 10=jump, 11=exception vector)
//   epc_write    capture PC-4 into EPC
//   cause_write  capture exception cause
//   cause        latched cause (00=illegal, 01=overflow, 10=mem timeout)
//   state_dbg    current state encoding
//   retired      retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem2reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             epc_write,
    output logic             cause_write,
    output logic [1:0]       cause,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_EXCEPT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_OVF     = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter value on the last permitted wait cycle; a stall seen at this
    // value is the MEM_TIMEOUT-th consecutive wait.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       cause_q, cause_d;
    logic             retire;
    logic             waiting;
    logic             timeout;

    // Next-state, retire and cause capture
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        // A completing access on the timeout cycle wins over the timeout.
        timeout = !mem_ready && (wait_q == WAIT_LAST);

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d = S_EXCEPT;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                // Only lw/sw reach here, and the IR still holds the opcode.
                state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_R_WB, S_ADDI_WB: begin
                if (alu_ovf) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXCEPT: state_d = S_FETCH;
            // Unused encodings 13-15 recover to FETCH.
            default:  state_d = S_FETCH;
        endcase

        // Wait counter restarts on every state change, counts only stalls.
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (waiting && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end

        retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    end

    // State register; reset discards any in-flight instruction without
    // retiring it or capturing a cause.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            retired_q <= '0;
            cause_q   <= CAUSE_ILLEGAL;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    // Output decode. Kept combinational because ir_write/pc_write in FETCH
    // and reg_write in the writeback states follow same-cycle inputs.
    always_comb begin
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem2reg     = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_source   = 2'b00;
        epc_write   = 1'b0;
        cause_write = 1'b0;
        cause       = 2'b00;

        if (!SYS_reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Precompute the branch target while the opcode decodes.
                    alu_src_b = 2'b11;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write = 1'b1;
                    mem2reg   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = !alu_ovf;
                end
                S_ADDI_WB: begin
                    reg_write = !alu_ovf;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_write  = alu_zero;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                S_EXCEPT: begin
                    epc_write   = 1'b1;
                    cause_write = 1'b1;
                    pc_write    = 1'b1;
                    pc_source   = 2'b11;
                    cause       = cause_q;
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = SYS_reset ? 4'd0 : state_q;
    assign retired   = SYS_reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4,  ST_MEM_WR = 4'd5;
    localparam logic [3:0] ST_R_EXEC = 4'd6, ST_R_WB = 4'd7,    ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP = 4'd9,   ST_ADDI_EXEC = 4'd10, ST_ADDI_WB = 4'd11;
    localparam logic [3:0] ST_EXCEPT = 4'd12;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic          SYS_clk, SYS_reset;
    logic [5:0]    opcode;
    logic          alu_zero, alu_ovf, mem_ready;
    logic          pc_write, iord, mem_read, mem_write, ir_write, mem2reg, reg_write, reg_dst;
    logic          alu_src_a, epc_write, cause_write;
    logic [1:0]    alu_src_b, alu_op, pc_source, cause;
    logic [3:0]    state_dbg;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .opcode(opcode),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem2reg(mem2reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .epc_write(epc_write), .cause_write(cause_write),
        .cause(cause), .state_dbg(state_dbg), .retired(retired)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [1:0] c;
    } step_t;

    step_t      seq[$];
    logic [5:0] cur_op;
    logic       cur_zero, cur_ovf, exp_retire;
    int         model_retired;
    int         n_cmp, n_fail;
    int         n_cyc, n_memw, n_irw, n_regw, n_pcw;

    // Expected outputs for one cycle, straight from the per-state output table.
    function automatic logic [22:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic zero, input logic ovf,
                                            input logic [1:0] c, input logic rst);
        logic pcw, io, mr, mw, irw, m2r, rw, rd, asa, epw, cw;
        logic [1:0] asb, aop, pcs, ca;
        {pcw, io, mr, mw, irw, m2r, rw, rd, asa, epw, cw} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00; ca = 2'b00;
        if (!rst) begin
            case (st)
                ST_FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
                ST_DECODE:    asb = 2'b11;
                ST_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
                ST_MEM_RD:    begin mr = 1; io = 1; end
                ST_MEM_WB:    begin rw = 1; m2r = 1; end
                ST_MEM_WR:    begin mw = 1; io = 1; end
                ST_R_EXEC:    begin asa = 1; aop = 2'b10; end
                ST_R_WB:      begin rd = 1; rw = !ovf; end
                ST_BRANCH:    begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = zero; end
                ST_JUMP:      begin pcs = 2'b10; pcw = 1; end
                ST_ADDI_EXEC: begin asa = 1; asb = 2'b10; end
                ST_ADDI_WB:   rw = !ovf;
                ST_EXCEPT:    begin epw = 1; cw = 1; pcw = 1; pcs = 2'b11; ca = c; end
                default: ;
            endcase
        end
        return {pcw, io, mr, mw, irw, m2r, rw, rd, asa, asb, aop, pcs, epw, cw, ca,
                (rst ? 4'd0 : st)};
    endfunction

    task automatic check_cycle(input logic [22:0] exp, input int exp_ret, input string name);
        logic [22:0] act;
        act = {pc_write, iord, mem_read, mem_write, ir_write, mem2reg, reg_write, reg_dst,
               alu_src_a, alu_src_b, alu_op, pc_source, epc_write, cause_write, cause, state_dbg};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s outputs t=%0t: got %06h required %06h", name, $time, act, exp);
        end
        n_cmp++;
        if (int'(retired) != exp_ret) begin
            n_fail++;
            $display("FAIL %s retired t=%0t: got %0d required %0d", name, $time, retired, exp_ret);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic [1:0] c);
        step_t s;
        s.st = st; s.rdy = rdy; s.c = c;
        seq.push_back(s);
    endtask

    // Instruction-level model: expands one instruction, with the given number
    // of fetch and memory stall cycles, into its expected state trace.
    task automatic build(input logic [5:0] op, input int fw, input int mw);
        logic [3:0] ms;
        seq.delete();
        exp_retire = 1'b0;
        cur_op = op;
        if (fw >= TO) begin
            repeat (TO) push(ST_FETCH, 1'b0, 2'b00);
            push(ST_EXCEPT, 1'b1, 2'b10);
            return;
        end
        repeat (fw) push(ST_FETCH, 1'b0, 2'b00);
        push(ST_FETCH, 1'b1, 2'b00);
        push(ST_DECODE, 1'b1, 2'b00);
        case (op)
            OP_LW, OP_SW: begin
                push(ST_MEM_ADDR, 1'b1, 2'b00);
                ms = (op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
                if (mw >= TO) begin
                    repeat (TO) push(ms, 1'b0, 2'b00);
                    push(ST_EXCEPT, 1'b1, 2'b10);
                end else begin
                    repeat (mw) push(ms, 1'b0, 2'b00);
                    push(ms, 1'b1, 2'b00);
                    if (op == OP_LW) push(ST_MEM_WB, 1'b1, 2'b00);
                    exp_retire = 1'b1;
                end
            end
            OP_R, OP_ADDI: begin
                push((op == OP_R) ? ST_R_EXEC : ST_ADDI_EXEC, 1'b1, 2'b00);
                push((op == OP_R) ? ST_R_WB : ST_ADDI_WB, 1'b1, 2'b00);
                if (cur_ovf) push(ST_EXCEPT, 1'b1, 2'b01);
                else exp_retire = 1'b1;
            end
            OP_BEQ: begin push(ST_BRANCH, 1'b1, 2'b00); exp_retire = 1'b1; end
            OP_J:   begin push(ST_JUMP, 1'b1, 2'b00);   exp_retire = 1'b1; end
            default: push(ST_EXCEPT, 1'b1, 2'b00);
        endcase
    endtask

    // Drives and checks up to n steps of the built trace, one per clock.
    task automatic run_seq(input int n);
        int lim;
        lim = (n < seq.size()) ? n : seq.size();
        n_cyc = 0; n_memw = 0; n_irw = 0; n_regw = 0; n_pcw = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge SYS_clk);
            SYS_reset = 1'b0;
            opcode    = cur_op;
            mem_ready = seq[i].rdy;
            alu_zero  = cur_zero;
            alu_ovf   = cur_ovf;
            #1;
            check_cycle(exp_vec(seq[i].st, seq[i].rdy, cur_zero, cur_ovf, seq[i].c, 1'b0),
                        model_retired, "step");
            n_cyc++;
            n_memw += int'(mem_write);
            n_irw  += int'(ir_write);
            n_regw += int'(reg_write);
            n_pcw  += int'(pc_write);
        end
        if (lim == seq.size() && exp_retire)
            model_retired = (model_retired + 1) % (1 << CW);
    endtask

    task automatic run(input logic [5:0] op, input int fw, input int mw,
                       input logic zero, input logic ovf);
        cur_zero = zero;
        cur_ovf  = ovf;
        build(op, fw, mw);
        run_seq(seq.size());
    endtask

    task automatic reset_step();
        @(negedge SYS_clk);
        SYS_reset = 1'b1;
        mem_ready = 1'b1;
        alu_ovf   = 1'b0;
        alu_zero  = 1'b1;
        #1;
        check_cycle(23'd0, 0, "reset");
        model_retired = 0;
    endtask

    // Reads retired just after the edge that closes the previous instruction.
    task automatic post_ret(input int exp);
        @(posedge SYS_clk);
        #1;
        SYS_reset = 1'b0;
        #1;
        lit("retired_after", int'(retired), exp);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; model_retired = 0;
        SYS_reset = 1'b1; opcode = 6'd0; alu_zero = 1'b0; alu_ovf = 1'b0; mem_ready = 1'b0;
        cur_op = 6'd0; cur_zero = 1'b0; cur_ovf = 1'b0; exp_retire = 1'b0;
        n_cyc = 0; n_memw = 0; n_irw = 0; n_regw = 0; n_pcw = 0;

        reset_step();
        reset_step();

        // lw with no stalls
        run(OP_LW, 0, 0, 1'b0, 1'b0);
        lit("lw_cycles", n_cyc, 5);
        lit("lw_regwrite", n_regw, 1);
        post_ret(1);

        // sw: 2 fetch stalls, 3 write stalls
        run(OP_SW, 2, 3, 1'b0, 1'b0);
        lit("sw_cycles", n_cyc, 9);
        lit("sw_memwrite", n_memw, 4);
        lit("sw_irwrite", n_irw, 1);
        post_ret(2);

        // beq taken then not taken
        run(OP_BEQ, 0, 0, 1'b1, 1'b0);
        lit("beq1_cycles", n_cyc, 3);
        lit("beq1_pcwrite", n_pcw, 2);
        run(OP_BEQ, 0, 0, 1'b0, 1'b0);
        lit("beq0_pcwrite", n_pcw, 1);
        post_ret(4);

        // add overflow -> exception, no retire
        run(OP_R, 0, 0, 1'b0, 1'b1);
        lit("addovf_cycles", n_cyc, 5);
        lit("addovf_regwrite", n_regw, 0);
        post_ret(4);

        run(OP_R, 0, 0, 1'b1, 1'b0);
        run(OP_ADDI, 1, 0, 1'b0, 1'b1);
        run(OP_ADDI, 0, 0, 1'b0, 1'b0);
        post_ret(6);

        // illegal opcode
        run(OP_BAD, 0, 0, 1'b0, 1'b0);
        lit("illegal_cycles", n_cyc, 3);

        // fetch timeout: exactly 4 stalled FETCH cycles then EXCEPT
        run(OP_J, 4, 0, 1'b0, 1'b0);
        lit("fetch_to_cycles", n_cyc, 5);

        // ready arrives on the timeout cycle: access completes
        run(OP_J, 3, 0, 1'b0, 1'b0);
        lit("fetch_late_cycles", n_cyc, 6);
        post_ret(7);

        // memory-side timeouts
        run(OP_LW, 0, 4, 1'b0, 1'b0);
        lit("lw_to_cycles", n_cyc, 8);
        run(OP_SW, 0, 4, 1'b0, 1'b1);
        run(OP_LW, 0, 3, 1'b0, 1'b0);
        post_ret(8);

        // counter wrap (CNT_W=4): 8 + 9 jumps = 17 -> 1
        for (int k = 0; k < 9; k++) run(OP_J, 0, 0, 1'b0, 1'b0);
        post_ret(1);

        // reset during MEM_RD aborts the load
        cur_zero = 1'b0; cur_ovf = 1'b0;
        build(OP_LW, 0, 2);
        run_seq(4);
        reset_step();
        post_ret(0);
        run(OP_LW, 0, 0, 1'b0, 1'b0);
        post_ret(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
